draw_list: RTL and testbench
============================

DRAW_LIST -- requirements
Module: draw_list

Interface
REQ-001 Parameter CORDW, default 11, coordinate width in bits (unsigned screen coordinates).
REQ-002 Parameter MAX_LINES, default 16, line-table depth; AW = $clog2(MAX_LINES) address width.
REQ-003 clk  in  1  sole clock, all logic on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 frame  in  1  single-cycle pulse requesting one pass over the table.
REQ-006 line_cnt  in  AW+1  number of table entries to draw, sampled on accepted frame.
REQ-007 off_x, off_y  in  CORDW+1 each  signed translation, sampled on accepted frame.
REQ-008 tbl_we  in  1  table write strobe.
REQ-009 tbl_addr  in  AW  table write address.
REQ-010 tbl_x0, tbl_y0, tbl_x1, tbl_y1  in  CORDW each  line endpoints written on tbl_we.
REQ-011 x0, y0, x1, y1  out  CORDW each  translated endpoints for the line drawer.
REQ-012 draw_start  out  1  single-cycle pulse; coordinates valid that cycle and held until the next draw_start.
REQ-013 line_done  in  1  single-cycle pulse from the line drawer, current line finished.
REQ-014 busy  out  1  high from accepted frame until frame_done.
REQ-015 frame_done  out  1  single-cycle pulse, pass complete.
REQ-016 tbl_err  out  1  single-cycle pulse, table write rejected.
REQ-017 frame_miss  out  1  sticky, a frame arrived while busy; cleared only by reset.

Function
REQ-018 FSM states: IDLE, FETCH, START, WAIT, FIN.
REQ-019 IDLE: frame=1 -> latch line_cnt, off_x, off_y; idx<=0; busy<=1; go to FETCH, or to FIN if line_cnt==0.
REQ-020 FETCH: synchronous table read of entry idx (1-cycle latency); go to START.
REQ-021 START: register translated coordinates, draw_start<=1 for exactly one cycle; go to WAIT.
REQ-022 WAIT: on line_done, if idx==latched line_cnt-1 go to FIN, else idx<=idx+1 and go to FETCH; line_done in any other state is ignored.
REQ-023 FIN: frame_done<=1 for one cycle, busy<=0; go to IDLE. Next frame accepted in the cycle after FIN.
REQ-024 line_cnt > MAX_LINES is clamped to MAX_LINES.
REQ-025 Translation: each coordinate = table value + offset, computed at CORDW+2 signed bits, saturated to [0, 2^CORDW-1].
REQ-026 Latency frame -> first draw_start: 3 cycles. line_done -> next draw_start: 3 cycles.
REQ-027 tbl_we while busy=0: entry written at the clock edge. tbl_we while busy=1: write discarded, tbl_err pulsed next cycle.
REQ-028 frame while busy=1 (including the FIN cycle): ignored, frame_miss<=1.
REQ-029 Table contents are unaffected by reset and undefined until written.

Reset
REQ-030 Reset asserted (any state, including mid-pass): FSM->IDLE, idx=0, x0/y0/x1/y1=0, draw_start=0, busy=0, frame_done=0, tbl_err=0, frame_miss=0; no draw_start in the first cycle after deassertion.

Structure
REQ-031 Package draw_pkg holds the state enum, the default CORDW, and a line_t struct {x0,y0,x1,y1}.
REQ-032 The table is a sub-module line_ram (1 write port, 1 synchronous read port, MAX_LINES x 4*CORDW).
REQ-033 Translation/saturation is a function in draw_pkg.

Verification
REQ-034 Write the 12 cube edges (e.g. entry0 = 200,200->400,200); line_cnt=12, offset 0; frame, line_done 5 cycles after each draw_start -> exactly 12 draw_starts with table values in order, then one frame_done, busy low.
REQ-035 off_x=-250, off_y=+1900, entry (200,200,400,400) -> x0=0, y0=2047, x1=150, y1=2047.
REQ-036 line_cnt=0, frame -> frame_done 2 cycles later, no draw_start.
REQ-037 tbl_we while busy -> tbl_err pulse, entry unchanged on the next pass; second frame while busy -> frame_miss=1, pass completes normally.
REQ-038 Reset asserted while in WAIT on line 5 -> all outputs 0 immediately; a new frame then restarts from entry 0.
REQ-039 line_cnt=20 with MAX_LINES=16 -> 16 draw_starts then frame_done.

Source files
------------

// File: rtl/draw_pkg.sv
// draw_pkg: shared types and helpers for the draw_list line sequencer.
//   DEF_CORDW - default screen coordinate width
//   state_e   - sequencer states
//   line_t    - one line-table entry at the default coordinate width
//   xlate     - translate a coordinate by a signed offset and clamp to screen
package draw_pkg;

  localparam int DEF_CORDW = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_START,
    ST_WAIT,
    ST_FIN
  } state_e;

  typedef struct packed {
    logic [DEF_CORDW-1:0] x0;
    logic [DEF_CORDW-1:0] y0;
    logic [DEF_CORDW-1:0] x1;
    logic [DEF_CORDW-1:0] y1;
  } line_t;

  // The sum is formed wider than cordw+2 bits so one function serves any
  // coordinate width; with v < 2^cordw and a cordw+1 bit offset the result is
  // identical to a cordw+2 bit signed sum. Result saturates to [0, 2^cordw-1].
  function automatic logic [31:0] xlate(input logic [31:0] v,
                                        input logic signed [31:0] off,
                                        input int cordw);
    logic signed [33:0] sum;
    logic signed [33:0] lim;
    sum = $signed({2'b00, v}) + 34'(off);
    lim = (34'sd1 <<< cordw) - 34'sd1;
    if (sum < 0) begin
      return '0;
    end else if (sum > lim) begin
      return lim[31:0];
    end else begin
      return sum[31:0];
    end
  endfunction

endpackage

// File: rtl/line_ram.sv
// line_ram: line table storage, one write port and one registered read port.
//   clk      - clock
//   we       - write strobe, wr_data stored at wr_addr on the rising edge
//   wr_addr  - write address
//   wr_data  - packed {x0, y0, x1, y1}
//   rd_addr  - read address, sampled every cycle
//   rd_data  - entry at rd_addr one cycle later
// Contents are not reset.
module line_ram #(
  parameter  int W     = 44,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/draw_list.sv
// draw_list: walks a table of line endpoints once per frame request, handing
// each translated line to a line drawer and waiting for it to finish.
//   clk, rst        - clock, asynchronous active-low reset
//   frame           - pulse, start one pass (ignored and flagged while busy)
//   line_cnt        - entries to draw, clamped to MAX_LINES
//   off_x, off_y    - signed translation applied to every endpoint
//   tbl_*           - table write port, honoured only while idle
//   x0, y0, x1, y1  - translated endpoints, held between draw_start pulses
//   draw_start      - pulse, endpoints valid
//   line_done       - pulse from the line drawer
//   busy            - pass in progress
//   frame_done      - pulse, pass complete
//   tbl_err         - pulse, a table write was discarded
//   frame_miss      - sticky, a frame arrived while busy
//
// state | meaning
// IDLE  | waiting for frame
// FETCH | table read of entry idx in flight
// START | register translated endpoints, pulse draw_start
// WAIT  | waiting for line_done
// FIN   | pulse frame_done, drop busy
module draw_list
  import draw_pkg::*;
#(
  parameter  int CORDW     = DEF_CORDW,
  parameter  int MAX_LINES = 16,
  localparam int AW        = $clog2(MAX_LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic [AW:0]      line_cnt,
  input  logic [CORDW:0]   off_x,
  input  logic [CORDW:0]   off_y,
  input  logic             tbl_we,
  input  logic [AW-1:0]    tbl_addr,
  input  logic [CORDW-1:0] tbl_x0,
  input  logic [CORDW-1:0] tbl_y0,
  input  logic [CORDW-1:0] tbl_x1,
  input  logic [CORDW-1:0] tbl_y1,
  output logic [CORDW-1:0] x0,
  output logic [CORDW-1:0] y0,
  output logic [CORDW-1:0] x1,
  output logic [CORDW-1:0] y1,
  output logic             draw_start,
  input  logic             line_done,
  output logic             busy,
  output logic             frame_done,
  output logic             tbl_err,
  output logic             frame_miss
);

  localparam logic [AW:0] MAX_CNT = (AW+1)'(MAX_LINES);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [AW:0]        cnt_q, cnt_d;
  logic [CORDW:0]     off_x_q, off_x_d, off_y_q, off_y_d;
  logic [CORDW-1:0]   x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
  logic               draw_start_q, draw_start_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               tbl_err_q, tbl_err_d;
  logic               frame_miss_q, frame_miss_d;
  logic [AW:0]        cnt_clamped;
  logic [4*CORDW-1:0] rd_data;
  logic [CORDW-1:0]   rd_x0, rd_y0, rd_x1, rd_y1;

  line_ram #(.W(4*CORDW), .DEPTH(MAX_LINES)) u_line_ram (
    .clk     (clk),
    .we      (tbl_we & ~busy_q),
    .wr_addr (tbl_addr),
    .wr_data ({tbl_x0, tbl_y0, tbl_x1, tbl_y1}),
    .rd_addr (idx_q),
    .rd_data (rd_data)
  );

  assign rd_x0 = rd_data[4*CORDW-1 -: CORDW];
  assign rd_y0 = rd_data[3*CORDW-1 -: CORDW];
  assign rd_x1 = rd_data[2*CORDW-1 -: CORDW];
  assign rd_y1 = rd_data[CORDW-1   -: CORDW];

  assign cnt_clamped = (line_cnt > MAX_CNT) ? MAX_CNT : line_cnt;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    off_x_d      = off_x_q;
    off_y_d      = off_y_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    draw_start_d = 1'b0;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    tbl_err_d    = tbl_we & busy_q;
    frame_miss_d = frame_miss_q | (frame & busy_q);

    case (state_q)
      ST_IDLE: begin
        if (frame) begin
          cnt_d   = cnt_clamped;
          off_x_d = off_x;
          off_y_d = off_y;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = (cnt_clamped == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = ST_START;
      end
      ST_START: begin
        x0_d         = CORDW'(xlate(32'(rd_x0), 32'($signed(off_x_q)), CORDW));
        y0_d         = CORDW'(xlate(32'(rd_y0), 32'($signed(off_y_q)), CORDW));
        x1_d         = CORDW'(xlate(32'(rd_x1), 32'($signed(off_x_q)), CORDW));
        y1_d         = CORDW'(xlate(32'(rd_y1), 32'($signed(off_y_q)), CORDW));
        draw_start_d = 1'b1;
        state_d      = ST_WAIT;
      end
      ST_WAIT: begin
        if (line_done) begin
          if ({1'b0, idx_q} == cnt_q - CNT_ONE) begin
            state_d = ST_FIN;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_FETCH;
          end
        end
      end
      ST_FIN: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      off_x_q      <= '0;
      off_y_q      <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      draw_start_q <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      tbl_err_q    <= 1'b0;
      frame_miss_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      off_x_q      <= off_x_d;
      off_y_q      <= off_y_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      draw_start_q <= draw_start_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      tbl_err_q    <= tbl_err_d;
      frame_miss_q <= frame_miss_d;
    end
  end

  assign x0         = x0_q;
  assign y0         = y0_q;
  assign x1         = x1_q;
  assign y1         = y1_q;
  assign draw_start = draw_start_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign tbl_err    = tbl_err_q;
  assign frame_miss = frame_miss_q;

endmodule

// File: tb/tb_draw_list.sv
module tb_draw_list;
  import draw_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame;
  logic [4:0]  line_cnt;
  logic [11:0] off_x, off_y;
  logic        tbl_we;
  logic [3:0]  tbl_addr;
  logic [10:0] tbl_x0, tbl_y0, tbl_x1, tbl_y1;
  logic [10:0] x0, y0, x1, y1;
  logic        draw_start;
  logic        line_done;
  logic        busy, frame_done, tbl_err, frame_miss;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frame_cyc;
  int fd_cnt   = 0;
  int fd_cyc   = 0;
  bit auto_ld  = 1'b1;

  logic [43:0] ds_q[$];
  int          ds_cyc_q[$];
  line_t       cube[16];

  draw_list dut (
    .clk(clk), .rst(rst), .frame(frame), .line_cnt(line_cnt),
    .off_x(off_x), .off_y(off_y), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_x0(tbl_x0), .tbl_y0(tbl_y0), .tbl_x1(tbl_x1), .tbl_y1(tbl_y1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .draw_start(draw_start),
    .line_done(line_done), .busy(busy), .frame_done(frame_done),
    .tbl_err(tbl_err), .frame_miss(frame_miss)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture draw_start / frame_done events away from the active edge.
  always @(negedge clk) begin
    if (draw_start) begin
      ds_q.push_back({x0, y0, x1, y1});
      ds_cyc_q.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc <= cyc;
    end
  end

  // Line drawer model: line_done five cycles after each draw_start.
  initial begin
    line_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (auto_ld && draw_start) begin
        repeat (5) @(posedge clk);
        #1 line_done = 1'b1;
        @(posedge clk);
        #1 line_done = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int a, input line_t l);
    tbl_addr = 4'(a);
    tbl_x0 = l.x0; tbl_y0 = l.y0; tbl_x1 = l.x1; tbl_y1 = l.y1;
    tbl_we = 1'b1;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic start_frame(input int n, input int ox, input int oy);
    line_cnt = 5'(n);
    off_x = 12'(ox);
    off_y = 12'(oy);
    frame = 1'b1;
    frame_cyc = cyc;
    tick();
    frame = 1'b0;
  endtask

  task automatic wait_fd(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    frame = 0; line_cnt = 0; off_x = 0; off_y = 0;
    tbl_we = 0; tbl_addr = 0; tbl_x0 = 0; tbl_y0 = 0; tbl_x1 = 0; tbl_y1 = 0;
    tick(); tick();
    n_checks++;
    if ({x0, y0, x1, y1} !== 44'h0) begin
      n_fail++; $display("FAIL reset_coords: got %h expected 0", {x0, y0, x1, y1});
    end
    n_checks++;
    if ({draw_start, busy, frame_done, tbl_err, frame_miss} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {draw_start, busy, frame_done, tbl_err, frame_miss});
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (draw_start !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_ds: got %b expected 0", draw_start);
    end
  endtask

  task automatic test_cube();
    int b, fb;
    bit ok;
    for (int i = 0; i < 12; i++) wr(i, cube[i]);
    b = ds_q.size();
    fb = fd_cnt;
    start_frame(12, 0, 0);
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL cube_timeout: got no frame_done expected one"); end
    repeat (3) tick();
    n_checks++;
    if (ds_q.size() - b !== 12) begin
      n_fail++; $display("FAIL cube_count: got %0d expected 12", ds_q.size() - b);
    end
    if (ds_q.size() - b == 12) begin
      for (int i = 0; i < 12; i++) begin
        n_checks++;
        if (ds_q[b+i] !== cube[i]) begin
          n_fail++; $display("FAIL cube_entry%0d: got %h expected %h", i, ds_q[b+i], cube[i]);
        end
      end
      n_checks++;
      if (ds_cyc_q[b] !== frame_cyc + 3) begin
        n_fail++; $display("FAIL cube_first_latency: got %0d expected %0d", ds_cyc_q[b] - frame_cyc, 3);
      end
      n_checks++;
      if (ds_cyc_q[b+1] - ds_cyc_q[b] !== 8) begin
        n_fail++; $display("FAIL cube_spacing: got %0d expected 8", ds_cyc_q[b+1] - ds_cyc_q[b]);
      end
      n_checks++;
      if (fd_cyc !== ds_cyc_q[b+11] + 7) begin
        n_fail++; $display("FAIL cube_fd_time: got %0d expected %0d", fd_cyc, ds_cyc_q[b+11] + 7);
      end
    end
    n_checks++;
    if (fd_cnt - fb !== 1) begin
      n_fail++; $display("FAIL cube_fd_count: got %0d expected 1", fd_cnt - fb);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL cube_busy: got %b expected 0", busy); end
  endtask

  task automatic test_translate();
    bit ok;
    line_t l;
    l.x0 = 200; l.y0 = 200; l.x1 = 400; l.y1 = 400;
    wr(0, l);
    start_frame(1, -250, 1900);
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL xlate_timeout: got no frame_done expected one"); end
    n_checks++;
    if (x0 !== 11'd0) begin n_fail++; $display("FAIL xlate_x0: got %0d expected 0", x0); end
    n_checks++;
    if (y0 !== 11'd2047) begin n_fail++; $display("FAIL xlate_y0: got %0d expected 2047", y0); end
    n_checks++;
    if (x1 !== 11'd150) begin n_fail++; $display("FAIL xlate_x1: got %0d expected 150", x1); end
    n_checks++;
    if (y1 !== 11'd2047) begin n_fail++; $display("FAIL xlate_y1: got %0d expected 2047", y1); end
    repeat (3) tick();
  endtask

  task automatic test_zero();
    int b;
    b = ds_q.size();
    start_frame(0, 0, 0);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b expected 1", busy); end
    tick();
    n_checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_fd: got fd=%b busy=%b expected fd=1 busy=0", frame_done, busy);
    end
    tick();
    n_checks++;
    if (frame_done !== 1'b0) begin n_fail++; $display("FAIL zero_fd_pulse: got %b expected 0", frame_done); end
    repeat (4) tick();
    n_checks++;
    if (ds_q.size() != b) begin
      n_fail++; $display("FAIL zero_no_ds: got %0d expected 0", ds_q.size() - b);
    end
  endtask

  task automatic test_busy_err();
    int b;
    bit ok;
    wr(0, cube[0]);
    b = ds_q.size();
    start_frame(3, 0, 0);
    tbl_addr = 4'd1; tbl_x0 = 11'd7; tbl_y0 = 11'd7; tbl_x1 = 11'd7; tbl_y1 = 11'd7;
    tbl_we = 1'b1;
    tick();
    tbl_we = 1'b0;
    n_checks++;
    if (tbl_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse: got %b expected 1", tbl_err); end
    frame = 1'b1;
    tick();
    frame = 1'b0;
    n_checks++;
    if (tbl_err !== 1'b0) begin n_fail++; $display("FAIL err_pulse_end: got %b expected 0", tbl_err); end
    n_checks++;
    if (frame_miss !== 1'b1) begin n_fail++; $display("FAIL miss_set: got %b expected 1", frame_miss); end
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL err_timeout: got no frame_done expected one"); end
    repeat (3) tick();
    n_checks++;
    if (ds_q.size() - b !== 3) begin
      n_fail++; $display("FAIL err_count: got %0d expected 3", ds_q.size() - b);
    end
    b = ds_q.size();
    start_frame(3, 0, 0);
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL err_timeout2: got no frame_done expected one"); end
    repeat (3) tick();
    n_checks++;
    if (ds_q.size() - b !== 3 || ds_q[b+1] !== cube[1]) begin
      n_fail++; $display("FAIL err_entry_kept: got %h expected %h", ds_q[b+1], cube[1]);
    end
    n_checks++;
    if (frame_miss !== 1'b1) begin n_fail++; $display("FAIL miss_sticky: got %b expected 1", frame_miss); end
  endtask

  task automatic test_reset_mid();
    int b;
    bit ok;
    b = ds_q.size();
    start_frame(12, 0, 0);
    for (int i = 0; i < 200 && ds_q.size() - b < 6; i++) tick();
    n_checks++;
    if (ds_q.size() - b !== 6) begin
      n_fail++; $display("FAIL mid_reach_line5: got %0d expected 6", ds_q.size() - b);
    end
    tick(); tick();
    n_checks++;
    if (x0 !== cube[5].x0) begin n_fail++; $display("FAIL mid_pre_x0: got %0d expected %0d", x0, cube[5].x0); end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({x0, y0, x1, y1} !== 44'h0) begin
      n_fail++; $display("FAIL mid_rst_coords: got %h expected 0", {x0, y0, x1, y1});
    end
    n_checks++;
    if ({draw_start, busy, frame_done, tbl_err, frame_miss} !== 5'b0) begin
      n_fail++;
      $display("FAIL mid_rst_flags: got %b expected 00000",
               {draw_start, busy, frame_done, tbl_err, frame_miss});
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (draw_start !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_release: got ds=%b busy=%b expected 0 0", draw_start, busy);
    end
    repeat (8) tick();
    b = ds_q.size();
    start_frame(2, 0, 0);
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL mid_timeout: got no frame_done expected one"); end
    repeat (3) tick();
    n_checks++;
    if (ds_q.size() - b !== 2 || ds_q[b] !== cube[0] || ds_cyc_q[b] !== frame_cyc + 3) begin
      n_fail++; $display("FAIL mid_restart: got %h expected %h", ds_q[b], cube[0]);
    end
  endtask

  task automatic test_clamp();
    int b;
    bit ok;
    for (int i = 12; i < 16; i++) wr(i, cube[i]);
    b = ds_q.size();
    start_frame(20, 0, 0);
    wait_fd(ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL clamp_timeout: got no frame_done expected one"); end
    repeat (3) tick();
    n_checks++;
    if (ds_q.size() - b !== 16) begin
      n_fail++; $display("FAIL clamp_count: got %0d expected 16", ds_q.size() - b);
    end
    if (ds_q.size() - b == 16) begin
      n_checks++;
      if (ds_q[b+15] !== cube[15] || ds_q[b+12] !== cube[12]) begin
        n_fail++; $display("FAIL clamp_tail: got %h expected %h", ds_q[b+15], cube[15]);
      end
    end
  endtask

  initial begin
    cube[0]  = '{11'd200, 11'd200, 11'd400, 11'd200};
    cube[1]  = '{11'd400, 11'd200, 11'd400, 11'd400};
    cube[2]  = '{11'd400, 11'd400, 11'd200, 11'd400};
    cube[3]  = '{11'd200, 11'd400, 11'd200, 11'd200};
    cube[4]  = '{11'd300, 11'd100, 11'd500, 11'd100};
    cube[5]  = '{11'd500, 11'd100, 11'd500, 11'd300};
    cube[6]  = '{11'd500, 11'd300, 11'd300, 11'd300};
    cube[7]  = '{11'd300, 11'd300, 11'd300, 11'd100};
    cube[8]  = '{11'd200, 11'd200, 11'd300, 11'd100};
    cube[9]  = '{11'd400, 11'd200, 11'd500, 11'd100};
    cube[10] = '{11'd400, 11'd400, 11'd500, 11'd300};
    cube[11] = '{11'd200, 11'd400, 11'd300, 11'd300};
    cube[12] = '{11'd10,  11'd20,  11'd30,  11'd40};
    cube[13] = '{11'd2047, 11'd0,  11'd0,   11'd2047};
    cube[14] = '{11'd1,   11'd2,   11'd3,   11'd4};
    cube[15] = '{11'd1000, 11'd1001, 11'd1002, 11'd1003};
    test_reset();
    test_cube();
    test_translate();
    test_zero();
    test_busy_err();
    test_reset_mid();
    test_clamp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
